// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchroniser and centre-of-bit sampling.
// Reports each byte with a one-cycle rx_done pulse, or a one-cycle frame_error pulse on a bad stop bit.
`default_nettype none

module uart_rx #(
  parameter int unsigned clock_frequency = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] baud_rate,
  input  logic        data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        rx_done,
  output logic        frame_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic [31:0] period;
  logic [31:0] count;
  logic [2:0]  index;
  logic [7:0]  shreg;
  logic [31:0] period_new;
  logic [31:0] half;

  // Bit period is computed from the live baud_rate but only captured on start detection.
  assign period_new = 32'(clock_frequency) / baud_rate;
  assign half       = {1'b0, period[31:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= S_IDLE;
      period      <= 32'd0;
      count       <= 32'd0;
      index       <= 3'd0;
      shreg       <= 8'h00;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_meta     <= data_in;
      rx_s        <= rx_meta;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        S_IDLE: begin
          count <= 32'd0;
          if (!rx_s && baud_rate != 32'd0) begin
            period <= period_new;
            state  <= S_START;
          end
        end
        S_START: begin
          if (count == half - 32'd1) begin
            count <= 32'd0;
            if (!rx_s) begin
              state     <= S_DATA;
              valid_out <= 1'b1;
              index     <= 3'd0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            count <= count + 32'd1;
          end
        end
        S_DATA: begin
          if (count == period - 32'd1) begin
            count        <= 32'd0;
            shreg[index] <= rx_s;
            if (index == 3'd7) begin
              state <= S_STOP;
            end else begin
              index <= index + 3'd1;
            end
          end else begin
            count <= count + 32'd1;
          end
        end
        S_STOP: begin
          // Leave at mid-stop-bit so a back-to-back start edge is not missed.
          if (count == period - 32'd1) begin
            count     <= 32'd0;
            valid_out <= 1'b0;
            if (rx_s) begin
              data_out <= shreg;
              rx_done  <= 1'b1;
              state    <= S_IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= S_BRK;
            end
          end else begin
            count <= count + 32'd1;
          end
        end
        S_BRK: begin
          // A held-low line must return high before another frame is accepted.
          count <= 32'd0;
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          count <= 32'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver that converts a serial line into bytes: 8 data bits, LSB first, no parity, 1 stop bit. It is the receive-side counterpart of the team's UART transmitter, uses the same `clock_frequency` / `baud_rate` bit-period convention, and sits between the RX pad and byte-level consumer logic. The line is resynchronised internally, each bit is sampled at its centre, and the block reports each byte as a one-cycle done pulse or a framing error.

## Interface
- `clock_frequency`, default 100000000: clk frequency in Hz.
- `clk` input 1: clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `baud_rate` input 32: line rate in baud. Read only at start-bit detection.
- `data_in` input 1: asynchronous serial line; idles high.
- `data_out` output 8: last correctly framed byte; held until the next good frame.
- `valid_out` output 1: busy flag; high from start-bit confirmation through the stop-bit sample.
- `rx_done` output 1: one-cycle pulse; `data_out` is valid and newly updated in that cycle.
- `frame_error` output 1: one-cycle pulse when the stop bit samples 0.

## Operation
- **Synchroniser.**
  - `data_in` passes through a 2-flop synchroniser (`rx_s`); the synchroniser flops reset to 1.
  - All FSM decisions use `rx_s` only.
- **Bit period.**
  - On IDLE->START, `P = clock_frequency / baud_rate` (32-bit integer divide) is latched into a register, and `H = P >> 1`.
  - `baud_rate` changes mid-frame have no effect.
  - If `baud_rate == 0`, the FSM stays in IDLE.
  - `P < 2` is unsupported.
- **Counters.**
  - `count` is 32 bits and clears on every state change.
  - `index` is 3 bits.
  - `shreg` is 8 bits; bit `index` receives the sample, so the byte is built LSB first.
- **States and transitions:**
  - **IDLE:** `rx_s == 0` -> START, `count = 0`.
  - **START:** count to `H-1`, then sample. `rx_s == 0` -> DATA, `valid_out = 1`, `index = 0`. `rx_s == 1` -> IDLE (glitch rejected; no outputs change).
  - **DATA:** at `count == P-1`, `shreg[index] <= rx_s` and `count = 0`.
    - If `index == 7`, go to STOP.
    - Otherwise increment `index`.
  - **STOP:** at `count == P-1`, sample and clear `valid_out`.
    - `rx_s == 1`: `data_out <= shreg`, pulse `rx_done`, go to IDLE.
    - `rx_s == 0`: pulse `frame_error`, keep `data_out`, go to BREAK.
  - **BREAK:** wait until `rx_s == 1`, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
  - Any unused state encoding -> IDLE.
- **Reset values:** `data_out = 8'h00`, `valid_out = 0`, `rx_done = 0`, `frame_error = 0`, state IDLE, `count = 0`, `index = 0`, synchroniser = 1.
- **Reset mid-frame:** the frame is abandoned and no `rx_done` is produced. The first frame after reset requires a fresh falling edge on `rx_s`.
- `rx_done` and `frame_error` are never high in the same cycle.

## Timing
- Let `t0` be the first cycle with `rx_s == 0` in IDLE; `rx_s` lags the pin by 2 cycles.
- Start sample occurs at `t0 + H`.
- Data bit k is sampled at `t0 + H + (k+1)*P`, for k = 0..7.
- Stop sample occurs at `t0 + H + 9*P`.
- `rx_done` / `frame_error` are registered and high in cycle `t0 + H + 9*P + 1`, with `data_out` updated in that same cycle.
- `valid_out` rises at `t0 + H + 1` and falls together with the `rx_done` / `frame_error` pulse.
- The FSM re-enters IDLE at mid-stop-bit, so back-to-back frames with zero idle time are received without loss.
- Tolerance: sampling at bit centre tolerates about ±4% combined baud mismatch across 10 bits.

## Test plan
- **Single byte.** `clock_frequency = 100e6`, `baud_rate = 115200` (P = 868, H = 434); drive 0xA5 -> exactly one `rx_done` pulse, `data_out == 8'hA5`, `frame_error` never high, `valid_out` high for 9*P cycles.
- **Glitch rejection.** Hold the line low for 200 cycles, then high -> FSM returns to IDLE; no `valid_out`, `rx_done` or `frame_error`; `data_out` unchanged.
- **Framing error.** Send 0x3C with stop bit 0, then hold low for 3*P -> one `frame_error` pulse, `data_out` keeps its prior value, and no decode occurs until the line returns high. A following frame 0x81 is then received correctly.
- **Back-to-back.** Send 0x00, 0xFF, 0x55 with no idle bits -> three `rx_done` pulses with values in order.
- **Reset mid-frame.** Assert `reset` for 1 cycle during bit 3 of 0x96 -> all outputs return to reset values, no `rx_done` for that frame; the next full frame 0x69 is received correctly.
- **Loopback.** Connect the team UART transmitter output to `data_in` at `baud_rate = 9600`; send bytes 0x00..0xFF -> every byte matches, zero framing errors.
